// File: rtl/bitrev_pkg.sv
// bitrev_pkg: shared defaults and FSM state encoding for the bit-reverse core host controller.
// Revision: 1.0
`default_nettype none

package bitrev_pkg;

  localparam int BITREV_DATA_W  = 32;
  localparam int BITREV_N_WORDS = 4;
  localparam int BITREV_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_READ      = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_HOLD      = 3'd5,
    ST_DRAIN     = 3'd6
  } bitrev_state_t;

endpackage

`default_nettype wire

// File: rtl/bitrev_timeout_cnt.sv
// bitrev_timeout_cnt: saturating wait counter; expire flags the cycle in which the count reaches TIMEOUT.
// Revision: 1.0
`default_nettype none

module bitrev_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (clear) begin
      tcnt <= '0;
    end else if (load && (tcnt != LIMIT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign expire = load && (tcnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bitrev_host_ctrl.sv
// bitrev_host_ctrl: loads a batch of words into the core, reads back one result per pulse and hands them downstream.
// Revision: 1.0
`default_nettype none

module bitrev_host_ctrl
  import bitrev_pkg::*;
#(
  parameter int DATA_W  = BITREV_DATA_W,
  parameter int N_WORDS = BITREV_N_WORDS,
  parameter int TIMEOUT = BITREV_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  output logic              start_flag_o,
  output logic [DATA_W-1:0] din_o,
  input  logic              done_flag_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              read_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = $clog2(N_WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);

  bitrev_state_t state;
  bitrev_state_t next_state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;
  logic          out_of_reset;
  logic          cmd_accept;
  logic          in_timed;
  logic          expire;

  assign cmd_accept = cmd_valid_i && cmd_ready_o;
  assign in_timed   = (state == ST_WAIT_DONE) || (state == ST_DRAIN);

  bitrev_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_timed),
    .load   (in_timed),
    .expire (expire)
  );

  // Keeps cmd_ready_o low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (cmd_accept) next_state = ST_LOAD;
      ST_LOAD:      if (src_valid_i && (wcnt == LAST_IDX)) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (expire) begin
          next_state = ST_IDLE;
        end else if (done_flag_i) begin
          next_state = ST_READ;
        end
      end
      ST_READ:      next_state = ST_CAPTURE;
      ST_CAPTURE:   next_state = ST_HOLD;
      ST_HOLD:      if (res_ready_i) next_state = (rcnt < LAST_IDX) ? ST_READ : ST_DRAIN;
      ST_DRAIN:     if (expire || !done_flag_i) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    src_ready_o  = 1'b0;
    start_flag_o = 1'b0;
    read_o       = 1'b0;
    busy_o       = (state != ST_IDLE);
    case (state)
      ST_IDLE: cmd_ready_o = out_of_reset;
      ST_LOAD: begin
        src_ready_o  = 1'b1;
        start_flag_o = 1'b1;
      end
      ST_READ: read_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word/result registers, batch counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_o       <= '0;
      res_data_o  <= '0;
      res_valid_o <= 1'b0;
      err_o       <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
    end else begin
      if (cmd_accept) begin
        err_o <= 1'b0;
        wcnt  <= '0;
        rcnt  <= '0;
      end
      if ((state == ST_LOAD) && src_valid_i) begin
        din_o <= src_data_i;
        wcnt  <= wcnt + 1'b1;
      end
      if (state == ST_CAPTURE) begin
        res_data_o  <= dout_i;
        res_valid_o <= 1'b1;
      end
      if ((state == ST_HOLD) && res_ready_i) begin
        res_valid_o <= 1'b0;
        rcnt        <= rcnt + 1'b1;
      end
      if (expire) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
